biquin_seq_ctrl: RTL and testbench
==================================

Name: biquin_seq_ctrl

Overview:
- Run controller for a cascade of bi-quinary (5421-code) decade counter digits.
- Arms, runs, pauses and clears a DIGITS-wide count driven by external tick events.
- Generates a per-digit carry enable for each digit stage.
- Compares the count against a programmed limit and reports completion over a req/ack handshake to the sequencing logic upstream.

Parameters:
DIGITS, 2, number of cascaded bi-quinary decade digits (1..8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
start  input  1  arm/resume request (level sampled each cycle)
stop  input  1  pause request while running
clr  input  1  synchronous clear of count and controller
tick  input  1  count event, one increment per cycle when accepted
limit  input  4*DIGITS  terminal value, 5421 code per digit {QA,QD,QC,QB}
count  output  4*DIGITS  current count, 5421 code per digit, digit 0 in bits [3:0]
digit_en  output  DIGITS  per-digit increment strobe for the current cycle
busy  output  1  high in RUN or HOLD
done_req  output  1  completion request, held until acknowledged
done_ack  input  1  completion acknowledge
lim_err  output  1  one-cycle pulse: start rejected, limit holds an illegal code

Behaviour:
- Digit code (5421): value v maps to QA = (v >= 5) and {QD,QC,QB} = v mod 5.
- Digit sequence: 0000,0001,0010,0011,0100,1000,1001,1010,1011,1100, then back to 0000.
- Codes with {QD,QC,QB} > 4 are illegal.
- Reset (rst = 0 at a clk edge): state IDLE; count = 0; digit_en = 0; busy = 0; done_req = 0; lim_err = 0.
- States: IDLE, RUN, HOLD, DONE. Priority per cycle: rst > clr > stop > start > tick.
- IDLE + start:
  - Illegal limit digit: stay IDLE, pulse lim_err for one cycle, count unchanged.
  - limit == 0: count <- 0, go to DONE.
  - Otherwise: count <- 0, go to RUN.
  - A tick in the same cycle as start is ignored.
- RUN + tick (no stop/clr): count increments by 1 at that edge.
  - digit_en[0] = 1.
  - digit_en[i] = 1 when digits 0..i-1 all equal 1100.
  - digit_en is combinational, valid in the same cycle as the accepted tick, and 0 otherwise.
- RUN: if the incremented count equals limit, go to DONE at the same edge (one-cycle latency from tick to done_req).
- RUN + stop: go to HOLD; a tick in that cycle is ignored and count is held.
- HOLD + start: resume RUN with count preserved; ticks are ignored in HOLD.
- DONE:
  - done_req = 1, busy = 0, count frozen at limit, ticks ignored.
  - done_ack sampled high: done_req drops next cycle, go to IDLE (count retained).
  - done_ack high while not in DONE is ignored.
- Full-scale wrap: all digits 1100 plus tick gives all 0000, with all digit_en high. This only occurs if limit changes mid-run; limit is sampled live every cycle.
- clr in any state: count <- 0, go to IDLE, done_req <- 0 at the next edge. Overrides a simultaneous done_ack or start.
- rst mid-operation: identical to reset above, regardless of state.
- busy = (state == RUN) || (state == HOLD), registered-state decode.

Optional Feature:
- Macro: BIQ_AUTORESTART_EN.
- Defined: on done_ack in DONE, count <- 0 and the controller returns directly to RUN (continuous periodic operation); done_req drops next cycle; stop or clr still exit as normal.
- Undefined: on done_ack the controller goes to IDLE with count retained, as described above.

Test Plan:
- DIGITS=2, reset then start=1, limit=8'h13 (value 13: digit1=0001, digit0=0011), 13 ticks:
  - count steps 00..13 in 5421 code.
  - done_req rises one cycle after the 13th tick.
  - digit_en[1] is high only on the tick taking 0x0C to 0x10.
- Running at count 5 (0x08), stop for 4 cycles with ticks, then start plus 3 ticks: count holds 0x08 in HOLD, reaches 0x0B, busy=1 throughout.
- limit=8'h00, start: DONE next cycle, done_req=1, count=0; done_ack=1: done_req=0 next cycle, state IDLE.
- limit=8'h07 (digit0 QD,QC,QB=111, illegal), start: lim_err pulses one cycle, state stays IDLE, count=0, busy=0.
- Running at count 0x1C (19), clr and tick asserted together: count=0, IDLE next cycle; rst=0 while in DONE: done_req=0, count=0.
- BIQ_AUTORESTART_EN defined, limit=8'h02: done_req after 2 ticks; ack: RUN with count=0; 2 more ticks: done_req again.

Source files
------------

// File: rtl/biquin_seq_ctrl_if.sv
// Control/status bundle between the upstream sequencer (master) and biquin_seq_ctrl (slave).
// Latency: none, wires only.
// Backpressure: done_req is held until done_ack is returned.
interface biquin_seq_ctrl_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  stop;
    logic                  clr;
    logic                  tick;
    logic [4*DIGITS-1:0]   limit;
    logic [4*DIGITS-1:0]   count;
    logic [DIGITS-1:0]     digit_en;
    logic                  busy;
    logic                  done_req;
    logic                  done_ack;
    logic                  lim_err;

    modport master (
        output start, stop, clr, tick, limit, done_ack,
        input  count, digit_en, busy, done_req, lim_err
    );

    modport slave (
        input  start, stop, clr, tick, limit, done_ack,
        output count, digit_en, busy, done_req, lim_err
    );
endinterface

// File: rtl/biquin_seq_ctrl.sv
// Run controller for a DIGITS-deep cascade of 5421-code decade counters; BIQ_AUTORESTART_EN re-arms on done_ack.
// Latency: count updates at the edge of an accepted tick; done_req one cycle after the terminal tick.
// Backpressure: done_req holds (count frozen, ticks ignored) until done_ack is sampled.
module biquin_seq_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    biquin_seq_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam int         W    = 4 * DIGITS;

    logic [1:0]        state;
    logic [W-1:0]      count_q;
    logic [W-1:0]      count_inc;
    logic [DIGITS-1:0] en;
    logic              tick_acc;
    logic              lim_ok;
    logic              lim_zero;
    logic              carry;
    logic              lim_err_q;

    // 0..4 step the quinary part; 4 -> 5 flips QA, 9 -> 0 wraps to 0000.
    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        if (d[2:0] == 3'd4) begin
            return d[3] ? 4'b0000 : 4'b1000;
        end
        return {d[3], d[2:0] + 3'd1};
    endfunction

    always_comb begin
        tick_acc  = rst && (state == RUN) && bus.tick && !bus.clr && !bus.stop;
        lim_ok    = 1'b1;
        carry     = tick_acc;
        en        = '0;
        count_inc = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.limit[4*i +: 3] > 3'd4) begin
                lim_ok = 1'b0;
            end
            en[i] = carry;
            if (carry) begin
                count_inc[4*i +: 4] = digit_inc(count_q[4*i +: 4]);
            end
            carry = carry && (count_q[4*i +: 4] == 4'b1100);
        end
        lim_zero = (bus.limit == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            count_q   <= '0;
            lim_err_q <= 1'b0;
        end else begin
            lim_err_q <= 1'b0;
            if (bus.clr) begin
                state   <= IDLE;
                count_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.stop) begin
                            if (!lim_ok) begin
                                lim_err_q <= 1'b1;
                            end else begin
                                count_q <= '0;
                                state   <= lim_zero ? DONE : RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.stop) begin
                            state <= HOLD;
                        end else if (tick_acc) begin
                            count_q <= count_inc;
                            // limit is sampled live, so a mid-run change can let the count wrap
                            if (count_inc == bus.limit) begin
                                state <= DONE;
                            end
                        end
                    end
                    HOLD: begin
                        if (bus.start && !bus.stop) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        if (bus.done_ack) begin
`ifdef BIQ_AUTORESTART_EN
                            count_q <= '0;
                            state   <= RUN;
`else
                            state   <= IDLE;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.digit_en = en;
    assign bus.busy     = (state == RUN) || (state == HOLD);
    assign bus.done_req = (state == DONE);
    assign bus.lim_err  = lim_err_q;
endmodule

// File: tb/tb_biquin_seq_ctrl.sv
// Directed bench for biquin_seq_ctrl (DIGITS=2); the autorestart scenario runs when BIQ_AUTORESTART_EN is defined.
module tb_biquin_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    biquin_seq_ctrl_if #(.DIGITS(2)) bus();
    biquin_seq_ctrl #(.DIGITS(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.start = 1'b0; bus.stop = 1'b0; bus.clr = 1'b0;
        bus.tick = 1'b0; bus.done_ack = 1'b0;
    endtask

    task automatic clear();
        quiet();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        bus.limit = 8'h00;
        rst = 1'b0;
        step(); step();
        checks++; if (bus.count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", bus.count); end
        checks++; if (bus.digit_en !== 2'b00) begin failures++; $display("FAIL reset_digit_en got=%b exp=00", bus.digit_en); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done_req !== 1'b0) begin failures++; $display("FAIL reset_done_req got=%b exp=0", bus.done_req); end
        checks++; if (bus.lim_err !== 1'b0) begin failures++; $display("FAIL reset_lim_err got=%b exp=0", bus.lim_err); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_count13();
        logic [7:0] exp_cnt [0:13];
        logic [1:0] exp_en;
        exp_cnt = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'h09,
                    8'h0A, 8'h0B, 8'h0C, 8'h10, 8'h11, 8'h12, 8'h13};
        bus.limit = 8'h13;
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.count !== 8'h00) begin failures++; $display("FAIL c13_armed got busy=%b count=%h exp busy=1 count=00", bus.busy, bus.count); end
        for (int i = 1; i <= 13; i++) begin
            bus.tick = 1'b1;
            #1;
            exp_en = (i == 10) ? 2'b11 : 2'b01;
            checks++; if (bus.digit_en !== exp_en) begin failures++; $display("FAIL c13_digit_en tick=%0d got=%b exp=%b", i, bus.digit_en, exp_en); end
            step();
            bus.tick = 1'b0;
            checks++; if (bus.count !== exp_cnt[i]) begin failures++; $display("FAIL c13_count tick=%0d got=%h exp=%h", i, bus.count, exp_cnt[i]); end
            checks++; if (bus.done_req !== (i == 13)) begin failures++; $display("FAIL c13_done_req tick=%0d got=%b exp=%b", i, bus.done_req, (i == 13)); end
        end
        bus.tick = 1'b1;
        #1;
        checks++; if (bus.digit_en !== 2'b00) begin failures++; $display("FAIL done_digit_en got=%b exp=00", bus.digit_en); end
        step();
        bus.tick = 1'b0;
        checks++; if (bus.count !== 8'h13 || bus.busy !== 1'b0) begin failures++; $display("FAIL done_frozen got count=%h busy=%b exp count=13 busy=0", bus.count, bus.busy); end
        bus.done_ack = 1'b1;
        step();
        bus.done_ack = 1'b0;
        checks++; if (bus.done_req !== 1'b0) begin failures++; $display("FAIL ack_done_req got=%b exp=0", bus.done_req); end
`ifdef BIQ_AUTORESTART_EN
        checks++; if (bus.count !== 8'h00 || bus.busy !== 1'b1) begin failures++; $display("FAIL ack_restart got count=%h busy=%b exp count=00 busy=1", bus.count, bus.busy); end
`else
        checks++; if (bus.count !== 8'h13 || bus.busy !== 1'b0) begin failures++; $display("FAIL ack_idle got count=%h busy=%b exp count=13 busy=0", bus.count, bus.busy); end
`endif
        clear();
    endtask

    task automatic test_hold();
        bus.limit = 8'h13;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.tick  = 1'b1;
        bus.done_ack = 1'b1;
        for (int i = 0; i < 5; i++) step();
        bus.done_ack = 1'b0;
        checks++; if (bus.count !== 8'h08 || bus.busy !== 1'b1) begin failures++; $display("FAIL hold_pre got count=%h busy=%b exp count=08 busy=1", bus.count, bus.busy); end
        bus.stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.digit_en !== 2'b00) begin failures++; $display("FAIL hold_digit_en cyc=%0d got=%b exp=00", i, bus.digit_en); end
            step();
            checks++; if (bus.count !== 8'h08 || bus.busy !== 1'b1) begin failures++; $display("FAIL hold_cnt cyc=%0d got count=%h busy=%b exp count=08 busy=1", i, bus.count, bus.busy); end
        end
        bus.stop  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.count !== 8'h08 || bus.busy !== 1'b1) begin failures++; $display("FAIL resume got count=%h busy=%b exp count=08 busy=1", bus.count, bus.busy); end
        for (int i = 0; i < 3; i++) step();
        bus.tick = 1'b0;
        checks++; if (bus.count !== 8'h0B || bus.busy !== 1'b1) begin failures++; $display("FAIL resume_cnt got count=%h busy=%b exp count=0b busy=1", bus.count, bus.busy); end
        clear();
    endtask

    task automatic test_zero_limit();
        bus.limit = 8'h00;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.done_req !== 1'b1 || bus.count !== 8'h00 || bus.busy !== 1'b0) begin failures++; $display("FAIL zero_done got req=%b count=%h busy=%b exp req=1 count=00 busy=0", bus.done_req, bus.count, bus.busy); end
        bus.done_ack = 1'b1;
        step();
        bus.done_ack = 1'b0;
        checks++; if (bus.done_req !== 1'b0) begin failures++; $display("FAIL zero_ack got req=%b exp=0", bus.done_req); end
`ifndef BIQ_AUTORESTART_EN
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zero_idle got busy=%b exp=0", bus.busy); end
`endif
        clear();
    endtask

    task automatic test_lim_err();
        bus.limit = 8'h07;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.lim_err !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'h00) begin failures++; $display("FAIL lim_err_pulse got err=%b busy=%b count=%h exp err=1 busy=0 count=00", bus.lim_err, bus.busy, bus.count); end
        step();
        checks++; if (bus.lim_err !== 1'b0 || bus.busy !== 1'b0 || bus.done_req !== 1'b0) begin failures++; $display("FAIL lim_err_after got err=%b busy=%b req=%b exp 0 0 0", bus.lim_err, bus.busy, bus.done_req); end
    endtask

    task automatic test_clr_rst();
        bus.limit = 8'hCC;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.tick  = 1'b1;
        for (int i = 0; i < 19; i++) step();
        bus.tick = 1'b0;
        checks++; if (bus.count !== 8'h1C) begin failures++; $display("FAIL clr_pre got=%h exp=1c", bus.count); end
        bus.clr  = 1'b1;
        bus.tick = 1'b1;
        #1;
        checks++; if (bus.digit_en !== 2'b00) begin failures++; $display("FAIL clr_digit_en got=%b exp=00", bus.digit_en); end
        step();
        quiet();
        checks++; if (bus.count !== 8'h00 || bus.busy !== 1'b0) begin failures++; $display("FAIL clr_result got count=%h busy=%b exp count=00 busy=0", bus.count, bus.busy); end
        bus.limit = 8'h01;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.tick  = 1'b1;
        step();
        bus.tick  = 1'b0;
        checks++; if (bus.done_req !== 1'b1 || bus.count !== 8'h01) begin failures++; $display("FAIL rst_pre got req=%b count=%h exp req=1 count=01", bus.done_req, bus.count); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if (bus.done_req !== 1'b0 || bus.count !== 8'h00 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_done got req=%b count=%h busy=%b exp 0 00 0", bus.done_req, bus.count, bus.busy); end
    endtask

    task automatic test_wrap();
        bus.limit = 8'hCC;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.tick  = 1'b1;
        for (int i = 0; i < 98; i++) step();
        checks++; if (bus.count !== 8'hCB) begin failures++; $display("FAIL wrap_pre got=%h exp=cb", bus.count); end
        bus.limit = 8'h01;
        #1;
        checks++; if (bus.digit_en !== 2'b01) begin failures++; $display("FAIL wrap_en0 got=%b exp=01", bus.digit_en); end
        step();
        checks++; if (bus.count !== 8'hCC || bus.done_req !== 1'b0) begin failures++; $display("FAIL wrap_full got count=%h req=%b exp count=cc req=0", bus.count, bus.done_req); end
        #1;
        checks++; if (bus.digit_en !== 2'b11) begin failures++; $display("FAIL wrap_en1 got=%b exp=11", bus.digit_en); end
        step();
        checks++; if (bus.count !== 8'h00 || bus.busy !== 1'b1) begin failures++; $display("FAIL wrap_zero got count=%h busy=%b exp count=00 busy=1", bus.count, bus.busy); end
        step();
        bus.tick = 1'b0;
        checks++; if (bus.count !== 8'h01 || bus.done_req !== 1'b1) begin failures++; $display("FAIL wrap_done got count=%h req=%b exp count=01 req=1", bus.count, bus.done_req); end
        clear();
    endtask

`ifdef BIQ_AUTORESTART_EN
    task automatic test_autorestart();
        bus.limit = 8'h02;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.tick  = 1'b1;
        step(); step();
        bus.tick  = 1'b0;
        checks++; if (bus.done_req !== 1'b1 || bus.count !== 8'h02) begin failures++; $display("FAIL ar_first got req=%b count=%h exp req=1 count=02", bus.done_req, bus.count); end
        bus.done_ack = 1'b1;
        step();
        bus.done_ack = 1'b0;
        checks++; if (bus.done_req !== 1'b0 || bus.busy !== 1'b1 || bus.count !== 8'h00) begin failures++; $display("FAIL ar_restart got req=%b busy=%b count=%h exp 0 1 00", bus.done_req, bus.busy, bus.count); end
        bus.tick = 1'b1;
        step(); step();
        bus.tick = 1'b0;
        checks++; if (bus.done_req !== 1'b1 || bus.count !== 8'h02) begin failures++; $display("FAIL ar_second got req=%b count=%h exp req=1 count=02", bus.done_req, bus.count); end
        clear();
    endtask
`endif

    initial begin
        test_reset();
        test_count13();
        test_hold();
        test_zero_limit();
        test_lim_err();
        test_clr_rst();
        test_wrap();
`ifdef BIQ_AUTORESTART_EN
        test_autorestart();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
